param_register_file: RTL and testbench
======================================

PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 SHALL have parameter DATA_W, 32, register width in bits.
REQ-002 SHALL have parameter DEPTH, 32, number of registers (power of two, 4..64); AW = clog2(DEPTH).
REQ-003 SHALL have parameter NUM_RD, 2, number of read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, 1, when 1 register 0 reads 0 and ignores writes.
REQ-005 SHALL have parameter LINK_REG, DEPTH-1, index written by the link port.
REQ-006 SHALL have parameter BYPASS, 1, when 1 same-cycle write data forwards to read ports.
REQ-007 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-008 SHALL have port reset  input  1  reset, synchronous, active-high; clock clk.
REQ-009 SHALL have port rd_addr  input  NUM_RD*AW  packed read addresses, port i at [i*AW +: AW].
REQ-010 SHALL have port rd_data  output  NUM_RD*DATA_W  packed read data.
REQ-011 SHALL have port rd_busy  output  NUM_RD  scoreboard pending bit of each read address.
REQ-012 SHALL have port wr_en  input  1  write-back enable.
REQ-013 SHALL have port wr_addr  input  AW  write-back address.
REQ-014 SHALL have port wr_data  input  DATA_W  write-back data.
REQ-015 SHALL have port link_en  input  1  write link_data to LINK_REG.
REQ-016 SHALL have port link_data  input  DATA_W  return address for link write.
REQ-017 SHALL have port sb_set  input  1  mark sb_addr pending (instruction issued).
REQ-018 SHALL have port sb_addr  input  AW  destination being issued.
REQ-019 SHALL have port busy_count  output  AW+1  number of pending registers.

Function
REQ-020 Reads SHALL be combinational: rd_data[i] = reg[rd_addr[i]], zero-latency.
REQ-021 Writes SHALL commit on the clk edge; visible through the array the cycle after.
REQ-022 With BYPASS=1, a read address matching an effective same-cycle write SHALL return that write's data; BYPASS=0 returns old contents.
REQ-023 wr_en and link_en targeting LINK_REG in the same cycle: wr_data SHALL win (for both storage and bypass).
REQ-024 wr_en and link_en to different registers SHALL both commit in the same cycle.
REQ-025 With ZERO_REG=1, writes/link/sb_set to address 0 SHALL be ignored and reads of 0 return 0, rd_busy 0.
REQ-026 Scoreboard: a write (wr_en or link_en) to register r SHALL clear busy[r] at the edge.
REQ-027 sb_set and a write to the same address in the same cycle: busy SHALL end set (new producer wins).
REQ-028 sb_set on an already-busy register SHALL leave it busy; busy_count unchanged.
REQ-029 rd_busy[i] SHALL reflect registered busy state; with BYPASS=1 it SHALL read 0 if the same-cycle write clears that address and no same-cycle sb_set targets it.
REQ-030 busy_count SHALL be a registered count equal to popcount of busy bits, updated with them, never wrapping (max DEPTH).
REQ-031 Out-of-range addresses cannot occur (DEPTH power of two); no error output.

Reset
REQ-032 While reset is high at a clk edge, all registers SHALL become 0, all busy bits 0, busy_count 0.
REQ-033 Reset SHALL override any concurrent wr_en, link_en, sb_set in that cycle.
REQ-034 After reset, rd_data all 0 and rd_busy all 0 until the first write/set edge.

Structure
REQ-035 Shared package regfile_pkg SHALL hold default DATA_W/DEPTH, LINK_REG default and the AW-from-DEPTH helper.
REQ-036 Scoreboard (busy bits, count, set/clear priority) SHALL be sub-module regfile_scoreboard; storage and bypass muxes stay in the top.

Verification
REQ-037 Reset, write 0xDEADBEEF to r5, next cycle read r5 on port 0 -> 0xDEADBEEF; r0 write 0x1 -> r0 reads 0.
REQ-038 BYPASS=1: wr r7=0x1234 and rd_addr0=7 same cycle -> rd_data0=0x1234; BYPASS=0 -> old value 0.
REQ-039 wr_en r31=0xAAAA and link_en 0x5555 same cycle -> r31=0xAAAA; wr r3 + link same cycle -> r3 and r31 both updated.
REQ-040 sb_set r4, then r9 -> busy_count 2, rd_busy for r4=1; wr r4 -> busy_count 1; sb_set r9 + wr r9 same cycle -> r9 busy, count 1.
REQ-041 Fill registers and set 10 busy bits, assert reset mid-sequence with wr_en -> all reads 0, busy_count 0.
REQ-042 NUM_RD=4, DATA_W=16, DEPTH=16: four distinct reads return independently written values.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and sizing helpers for the parameterised register file.
// Latency: none (package only).
// Backpressure: none.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_NUM_RD = 2;

  // Address width needed to index a register array of the given depth.
  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Link register sits at the top of the array by default.
  function automatic int link_default(input int depth);
    return depth - 1;
  endfunction

  localparam int DEF_LINK_REG = link_default(DEF_DEPTH);

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending (busy) bits with a registered popcount of busy entries.
// Latency: set/clear commit at the clk edge; the forwarded view is combinational.
// Backpressure: none; set wins over a same-cycle clear of the same register.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter bit BYPASS = 1'b1,
  localparam int AW    = addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_set,
  input  logic [AW-1:0]    i_set_addr,
  input  logic             i_clr_a,
  input  logic [AW-1:0]    i_clr_a_addr,
  input  logic             i_clr_b,
  input  logic [AW-1:0]    i_clr_b_addr,
  output logic [DEPTH-1:0] o_busy_view,
  output logic [AW:0]      o_busy_count
);

  logic [DEPTH-1:0] r_busy;
  logic [AW:0]      r_count;
  logic [DEPTH-1:0] w_set_mask;
  logic [DEPTH-1:0] w_clr_mask;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [AW:0]      w_count_nxt;

  // Next busy vector: clears first, then the issuing producer re-marks its destination.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set)   w_set_mask[i_set_addr]   = 1'b1;
    if (i_clr_a) w_clr_mask[i_clr_a_addr] = 1'b1;
    if (i_clr_b) w_clr_mask[i_clr_b_addr] = 1'b1;
    w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;
  end

  // Popcount of the next busy vector so the count register moves with the bits.
  always_comb begin
    w_count_nxt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_count_nxt = w_count_nxt + (AW+1)'(w_busy_nxt[k]);
    end
  end

  // Busy state and count registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_count <= w_count_nxt;
    end
  end

  // A register being written this cycle looks free unless it is also being re-issued.
  assign o_busy_view  = BYPASS ? (r_busy & ~(w_clr_mask & ~w_set_mask)) : r_busy;
  assign o_busy_count = r_count;

endmodule

// File: rtl/param_register_file.sv
// Multi-port register file with write-back, link-register write and issue scoreboard.
// Latency: reads combinational (optional same-cycle forwarding); writes commit at clk edge.
// Backpressure: none; write-back beats link on a shared target, reset beats everything.
module param_register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter bit ZERO_REG = 1'b1,
  parameter int LINK_REG = link_default(DEPTH),
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = addr_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     link_en,
  input  logic [DATA_W-1:0]        link_data,
  input  logic                     sb_set,
  input  logic [AW-1:0]            sb_addr,
  output logic [AW:0]              busy_count
);

  localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic              w_wr_ok;
  logic              w_link_ok;
  logic              w_set_ok;
  logic [DEPTH-1:0]  w_busy_view;

  // Qualify this cycle's writes: register 0 is hardwired when enabled, write-back
  // shadows a link write aimed at the same register, and reset cancels everything.
  assign w_wr_ok   = wr_en && !reset && !(ZERO_REG && (wr_addr == '0));
  assign w_link_ok = link_en && !reset && !(ZERO_REG && (LINK_A == '0))
                     && !(wr_en && (wr_addr == LINK_A));
  assign w_set_ok  = sb_set && !reset && !(ZERO_REG && (sb_addr == '0));

  // Storage array: both qualified writes land on the edge; they never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_regs[k] <= '0;
      end
    end else begin
      if (w_link_ok) r_regs[LINK_A]  <= link_data;
      if (w_wr_ok)   r_regs[wr_addr] <= wr_data;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]     w_addr;
    logic [DATA_W-1:0] w_dat;

    assign w_addr = rd_addr[i*AW +: AW];

    // Read mux: array contents, overridden by same-cycle link then write-back data.
    always_comb begin
      w_dat = r_regs[w_addr];
      if (BYPASS && w_link_ok && (w_addr == LINK_A))  w_dat = link_data;
      if (BYPASS && w_wr_ok && (w_addr == wr_addr))   w_dat = wr_data;
      if (ZERO_REG && (w_addr == '0))                 w_dat = '0;
    end

    assign rd_data[i*DATA_W +: DATA_W] = w_dat;
    assign rd_busy[i] = w_busy_view[w_addr];
  end

  regfile_scoreboard #(
    .DEPTH  (DEPTH),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk          (clk),
    .reset        (reset),
    .i_set        (w_set_ok),
    .i_set_addr   (sb_addr),
    .i_clr_a      (w_wr_ok),
    .i_clr_a_addr (wr_addr),
    .i_clr_b      (w_link_ok),
    .i_clr_b_addr (LINK_A),
    .o_busy_view  (w_busy_view),
    .o_busy_count (busy_count)
  );

endmodule

// File: tb/tb_param_register_file.sv
module tb_param_register_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  // Default geometry: instance A forwards, instance B does not; same inputs.
  logic [9:0]  rd_addr;
  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_busy_a, rd_busy_b;
  logic        wr_en, link_en, sb_set;
  logic [4:0]  wr_addr, sb_addr;
  logic [31:0] wr_data, link_data;
  logic [5:0]  bc_a, bc_b;
  // Narrow four-port instance C.
  logic [15:0] c_rd_addr;
  logic [63:0] c_rd_data;
  logic [3:0]  c_rd_busy;
  logic        c_wr_en, c_link_en, c_sb_set;
  logic [3:0]  c_wr_addr, c_sb_addr;
  logic [15:0] c_wr_data, c_link_data;
  logic [4:0]  c_bc;

  param_register_file #(.BYPASS(1'b1)) dut_a (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .link_en(link_en),
    .link_data(link_data), .sb_set(sb_set), .sb_addr(sb_addr), .busy_count(bc_a));

  param_register_file #(.BYPASS(1'b0)) dut_b (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .link_en(link_en),
    .link_data(link_data), .sb_set(sb_set), .sb_addr(sb_addr), .busy_count(bc_b));

  param_register_file #(.DATA_W(16), .DEPTH(16), .NUM_RD(4)) dut_c (
    .clk(clk), .reset(reset), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data), .link_en(c_link_en),
    .link_data(c_link_data), .sb_set(c_sb_set), .sb_addr(c_sb_addr), .busy_count(c_bc));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: architectural register contents and pending flags.
  logic [31:0] m_reg  [32];
  bit          m_busy [32];
  logic [15:0] c_reg  [16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; link_en = 1'b0; sb_set = 1'b0;
    wr_addr = '0; sb_addr = '0; wr_data = '0; link_data = '0;
    c_wr_en = 1'b0; c_link_en = 1'b0; c_sb_set = 1'b0;
    c_wr_addr = '0; c_sb_addr = '0; c_wr_data = '0; c_link_data = '0;
  endtask

  task automatic zero_models();
    for (int k = 0; k < 32; k++) begin m_reg[k] = '0; m_busy[k] = 1'b0; end
    for (int k = 0; k < 16; k++) c_reg[k] = '0;
  endtask

  // Called just after a falling edge with inputs applied: checks A/B, then advances one clock.
  task automatic cyc(input string tag);
    logic [31:0] nxt [32];
    bit          wrt [32];
    logic [4:0]  a;
    int          cnt;
    bit          eb;
    #1;
    nxt = m_reg;
    for (int k = 0; k < 32; k++) wrt[k] = 1'b0;
    // Link lands first, write-back overwrites it; register 0 never changes.
    if (link_en) begin nxt[31] = link_data; wrt[31] = 1'b1; end
    if (wr_en)   begin nxt[wr_addr] = wr_data; wrt[wr_addr] = 1'b1; end
    nxt[0] = '0; wrt[0] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      a = rd_addr[p*5 +: 5];
      check($sformatf("%s.rdA%0d", tag, p), 64'(rd_data_a[p*32 +: 32]), 64'(wrt[a] ? nxt[a] : m_reg[a]));
      check($sformatf("%s.rdB%0d", tag, p), 64'(rd_data_b[p*32 +: 32]), 64'(m_reg[a]));
      eb = m_busy[a] && !(wrt[a] && !(sb_set && sb_addr == a));
      check($sformatf("%s.bsyA%0d", tag, p), 64'(rd_busy_a[p]), 64'(eb));
      check($sformatf("%s.bsyB%0d", tag, p), 64'(rd_busy_b[p]), 64'(m_busy[a]));
    end
    cnt = 0;
    foreach (m_busy[k]) if (m_busy[k]) cnt++;
    check({tag, ".cntA"}, 64'(bc_a), 64'(cnt));
    check({tag, ".cntB"}, 64'(bc_b), 64'(cnt));
    @(posedge clk);
    m_reg = nxt;
    for (int k = 0; k < 32; k++) if (wrt[k]) m_busy[k] = 1'b0;
    if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1'b1;
    @(negedge clk);
  endtask

  task automatic cyc_c(input string tag);
    logic [15:0] nxt [16];
    bit          wrt [16];
    logic [3:0]  a;
    #1;
    nxt = c_reg;
    for (int k = 0; k < 16; k++) wrt[k] = 1'b0;
    if (c_wr_en) begin nxt[c_wr_addr] = c_wr_data; wrt[c_wr_addr] = 1'b1; end
    nxt[0] = '0; wrt[0] = 1'b0;
    for (int p = 0; p < 4; p++) begin
      a = c_rd_addr[p*4 +: 4];
      check($sformatf("%s.rdC%0d", tag, p), 64'(c_rd_data[p*16 +: 16]), 64'(wrt[a] ? nxt[a] : c_reg[a]));
    end
    check({tag, ".bsyC"}, 64'(c_rd_busy), 64'd0);
    check({tag, ".cntC"}, 64'(c_bc), 64'd0);
    @(posedge clk);
    c_reg = nxt;
    @(negedge clk);
  endtask

  // Reset with arbitrary write/link/set traffic that must be discarded.
  task automatic do_reset();
    reset = 1'b1;
    wr_en = 1'b1; wr_addr = 5'($urandom_range(1, 31)); wr_data = $urandom;
    link_en = 1'b1; link_data = $urandom;
    sb_set = 1'b1; sb_addr = 5'($urandom_range(1, 31));
    c_wr_en = 1'b1; c_wr_addr = 4'($urandom_range(1, 15)); c_wr_data = 16'($urandom);
    @(posedge clk);
    zero_models();
    @(negedge clk);
    reset = 1'b0;
    idle();
  endtask

  initial begin
    reset = 1'b1;
    rd_addr = '0; c_rd_addr = '0;
    idle();
    zero_models();
    @(negedge clk);
    do_reset();

    // Reset state.
    rd_addr = {5'd31, 5'd5};
    c_rd_addr = {4'd15, 4'd9, 4'd5, 4'd1};
    #1;
    check("rst.rd", rd_data_a, 64'd0);
    check("rst.busy", 64'(rd_busy_a), 64'd0);
    check("rst.cnt", 64'(bc_a), 64'd0);
    check("rst.rdC", c_rd_data, 64'd0);
    cyc("rst");

    // Write r5, read it back next cycle; r0 stays zero.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr = '0;
    cyc("w5");
    idle(); rd_addr = {5'd0, 5'd5};
    #1 check("r5", 64'(rd_data_a[31:0]), 64'hDEADBEEF);
    check("r5.nobyp", 64'(rd_data_b[31:0]), 64'hDEADBEEF);
    cyc("r5");
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1; rd_addr = {5'd0, 5'd0};
    cyc("w0");
    idle();
    #1 check("r0", 64'(rd_data_a[31:0]), 64'd0);
    cyc("r0");

    // Same-cycle forwarding vs. none.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234; rd_addr = {5'd0, 5'd7};
    #1 check("byp7", 64'(rd_data_a[31:0]), 64'h1234);
    check("nobyp7", 64'(rd_data_b[31:0]), 64'h0);
    cyc("byp");

    // Write-back beats link on r31; separate targets both commit.
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'hAAAA; link_en = 1'b1; link_data = 32'h5555;
    rd_addr = {5'd0, 5'd31};
    #1 check("lnk.byp", 64'(rd_data_a[31:0]), 64'hAAAA);
    cyc("lnk1");
    idle();
    #1 check("r31", 64'(rd_data_a[31:0]), 64'hAAAA);
    cyc("r31");
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33; link_en = 1'b1; link_data = 32'h77;
    cyc("lnk2");
    idle(); rd_addr = {5'd31, 5'd3};
    #1 check("r3", 64'(rd_data_a[31:0]), 64'h33);
    check("r31b", 64'(rd_data_a[63:32]), 64'h77);
    cyc("r3");

    // Scoreboard set/clear ordering.
    sb_set = 1'b1; sb_addr = 5'd4; cyc("sb4");
    sb_set = 1'b1; sb_addr = 5'd9; cyc("sb9");
    idle(); rd_addr = {5'd9, 5'd4};
    #1 check("sb.cnt2", 64'(bc_a), 64'd2);
    check("sb.bsy", 64'(rd_busy_a), 64'b11);
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
    #1 check("sb.clrbyp", 64'(rd_busy_a[0]), 64'd0);
    check("sb.clrnobyp", 64'(rd_busy_b[0]), 64'd1);
    cyc("wr4");
    idle();
    #1 check("sb.cnt1", 64'(bc_a), 64'd1);
    sb_set = 1'b1; sb_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    cyc("sbwr9");
    idle();
    #1 check("sb9.cnt", 64'(bc_a), 64'd1);
    check("sb9.bsy", 64'(rd_busy_a[1]), 64'd1);
    cyc("sb9chk");

    // Fill, mark ten registers busy, then reset mid-stream with traffic.
    idle(); do_reset();
    for (int k = 1; k <= 10; k++) begin
      wr_en = 1'b1; wr_addr = 5'(k); wr_data = $urandom;
      sb_set = 1'b1; sb_addr = 5'(k + 10);
      rd_addr = 10'($urandom);
      cyc("fill");
    end
    idle();
    #1 check("fill.cnt", 64'(bc_a), 64'd10);
    do_reset();
    for (int k = 0; k < 32; k += 2) begin
      rd_addr = {5'(k + 1), 5'(k)};
      #1 check($sformatf("post.r%0d", k), rd_data_a, 64'd0);
      cyc("post");
    end

    // Randomised traffic with directed collisions and occasional reset.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset();
      end else begin
        wr_en = 1'($urandom); wr_addr = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom);
        wr_data = $urandom;
        link_en = ($urandom_range(0, 2) == 0); link_data = $urandom;
        sb_set = 1'($urandom);
        sb_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
        rd_addr[4:0] = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom);
        rd_addr[9:5] = ($urandom_range(0, 2) == 0) ? 5'd31 : 5'($urandom);
        cyc("rnd");
      end
    end

    // Four-port narrow instance: independent values on distinct ports.
    idle();
    c_wr_en = 1'b1; c_wr_addr = 4'd2;  c_wr_data = 16'h1111; cyc_c("cw2");
    c_wr_en = 1'b1; c_wr_addr = 4'd5;  c_wr_data = 16'h2222; cyc_c("cw5");
    c_wr_en = 1'b1; c_wr_addr = 4'd9;  c_wr_data = 16'h3333; cyc_c("cw9");
    c_wr_en = 1'b1; c_wr_addr = 4'd14; c_wr_data = 16'h4444; cyc_c("cw14");
    idle(); c_rd_addr = {4'd14, 4'd9, 4'd5, 4'd2};
    #1 check("c4", c_rd_data, 64'h4444_3333_2222_1111);
    cyc_c("c4");
    for (int n = 0; n < 200; n++) begin
      c_wr_en = 1'($urandom); c_wr_addr = 4'($urandom); c_wr_data = 16'($urandom);
      c_rd_addr = 16'($urandom);
      if ($urandom_range(0, 2) == 0) c_rd_addr[7:4] = c_wr_addr;
      cyc_c("crnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
